// File: rtl/fifo_push_arbiter_if.sv
// Push-side bundle between NUM_REQ producers, the push arbiter and one sync_fifo.
// The slave modport is the arbiter's view; the master modport drives it.
interface fifo_push_arbiter_if #(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned WIDTH     = 7,
    parameter int unsigned CNT_WIDTH = 16
);
    logic [NUM_REQ-1:0]             i_req_valid;
    logic [NUM_REQ*(WIDTH+1)-1:0]   i_req_data;
    logic [NUM_REQ-1:0]             o_req_ready;
    logic                           o_push_valid;
    logic [WIDTH:0]                 o_push_data;
    logic                           i_push_ready;
    logic [NUM_REQ-1:0]             o_grant;
    logic                           o_busy;
    logic                           i_cnt_clr;
    logic [NUM_REQ*CNT_WIDTH-1:0]   o_beat_cnt;

    modport master (
        output i_req_valid, i_req_data, i_push_ready, i_cnt_clr,
        input  o_req_ready, o_push_valid, o_push_data, o_grant, o_busy, o_beat_cnt
    );

    modport slave (
        input  i_req_valid, i_req_data, i_push_ready, i_cnt_clr,
        output o_req_ready, o_push_valid, o_push_data, o_grant, o_busy, o_beat_cnt
    );
endinterface

// File: rtl/fifo_push_arbiter.sv
// Round-robin burst arbiter sharing one sync_fifo push port among NUM_REQ producers.
// Define FIFO_PUSH_ARB_STATS_EN to add saturating per-requester accepted-beat counters.
module fifo_push_arbiter #(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned WIDTH     = 7,
    parameter int unsigned MAX_BURST = 4,
    parameter int unsigned CNT_WIDTH = 16
) (
    input logic                i_clk,
    input logic                i_rst,
    fifo_push_arbiter_if.slave bus
);
    localparam int unsigned IDX_W = $clog2(NUM_REQ);
    localparam int unsigned BW    = WIDTH + 1;

    typedef enum logic [0:0] {StIdle, StGrant} state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] grant_q, grant_d;
    logic [IDX_W-1:0] last_q, last_d;
    logic [7:0]       burst_q, burst_d;

    logic             in_grant, valid_g, beat, rel_burst, rel_drop;
    logic [IDX_W-1:0] scan_base, cand, win_idx;
    logic             scan_self, win_found;

    assign in_grant  = (state_q == StGrant);
    assign valid_g   = bus.i_req_valid[grant_q];
    assign beat      = in_grant && valid_g && bus.i_push_ready;
    assign rel_burst = beat && (burst_q == 8'(MAX_BURST - 1));
    assign rel_drop  = in_grant && !valid_g;
    // The current holder competes again (last in order) only when its burst ran out.
    assign scan_base = in_grant ? grant_q : last_q;
    assign scan_self = !in_grant || rel_burst;

    always_comb begin
        cand      = '0;
        win_idx   = '0;
        win_found = 1'b0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            cand = IDX_W'((32'(scan_base) + i) % NUM_REQ);
            if (!win_found && (i < NUM_REQ || scan_self) && bus.i_req_valid[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d           = state_q;
        grant_d           = grant_q;
        last_d            = last_q;
        burst_d           = burst_q;
        bus.o_push_valid  = 1'b0;
        bus.o_push_data   = '0;
        bus.o_req_ready   = '0;
        bus.o_grant       = '0;
        bus.o_busy        = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (win_found) begin
                    state_d = StGrant;
                    grant_d = win_idx;
                    burst_d = '0;
                end
            end
            StGrant: begin
                bus.o_busy               = 1'b1;
                bus.o_grant[grant_q]     = 1'b1;
                bus.o_push_valid         = valid_g;
                bus.o_push_data          = bus.i_req_data[32'(grant_q)*BW +: BW];
                bus.o_req_ready[grant_q] = bus.i_push_ready;
                if (rel_burst || rel_drop) begin
                    last_d = grant_q;
                    if (win_found) begin
                        grant_d = win_idx;
                        burst_d = '0;
                    end else begin
                        state_d = StIdle;
                    end
                end else if (beat) begin
                    burst_d = burst_q + 8'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= StIdle;
            grant_q <= '0;
            last_q  <= IDX_W'(NUM_REQ - 1);
            burst_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            burst_q <= burst_d;
        end
    end

`ifdef FIFO_PUSH_ARB_STATS_EN
    logic [NUM_REQ-1:0][CNT_WIDTH-1:0] cnt_q;

    // Clear wins over a same-cycle beat; counters stick at all-ones.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt_q <= '0;
        end else if (bus.i_cnt_clr) begin
            cnt_q <= '0;
        end else if (beat && (cnt_q[grant_q] != '1)) begin
            cnt_q[grant_q] <= cnt_q[grant_q] + 1'b1;
        end
    end

    assign bus.o_beat_cnt = cnt_q;
`else
    logic unused_cnt_clr;
    assign unused_cnt_clr = bus.i_cnt_clr;
    assign bus.o_beat_cnt = '0;
`endif
endmodule

// File: tb/tb_fifo_push_arbiter.sv
// Self-checking bench for fifo_push_arbiter: table-driven first transaction plus
// scoreboarded multi-cycle sequences (fairness, backpressure, handover, reset, stats).
module tb_fifo_push_arbiter;
    localparam int NR = 4;
    localparam int W  = 7;
    localparam int MB = 4;
`ifdef FIFO_PUSH_ARB_STATS_EN
    localparam int CW = 4;
`else
    localparam int CW = 16;
`endif

    typedef logic [7:0] byte_q_t [$];
    typedef struct {
        int         idx;
        logic [7:0] data;
    } exp_t;
    typedef struct {
        logic [3:0] valid;
        logic       ready;
        logic [7:0] d1;
        logic [3:0] eg;
        logic       epv;
        logic [3:0] err;
        logic       ebusy;
        logic [7:0] ed;
    } vec_t;

    logic    clk = 1'b0;
    logic    rst = 1'b1;
    int      checks = 0;
    int      errors = 0;
    byte_q_t src [NR];
    logic [NR-1:0] en;
    logic    src_mode;
    exp_t    exp_q [$];
    int      beat_log [$];
    vec_t    vecs [6];
    int      n;
    int      bp_exp [8];
    int      vd_exp [7];

    fifo_push_arbiter_if #(.NUM_REQ(NR), .WIDTH(W), .CNT_WIDTH(CW)) bus ();

    fifo_push_arbiter #(
        .NUM_REQ  (NR),
        .WIDTH    (W),
        .MAX_BURST(MB),
        .CNT_WIDTH(CW)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required $finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, expv);
        end
    endtask

    function automatic bit pending();
        for (int k = 0; k < NR; k++) if (src[k].size() > 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic load(input int k, input int cnt, input logic [7:0] base);
        for (int i = 0; i < cnt; i++) src[k].push_back(base + 8'(i));
    endtask

    // Monitor: invariants, producer handshakes into the scoreboard, FIFO beats out of it.
    task automatic sample();
        int   g;
        exp_t e;
        chk("grant_onehot0", 64'($onehot0(bus.o_grant)), 64'd1);
        chk("ready_onehot0", 64'($onehot0(bus.o_req_ready)), 64'd1);
        if (!bus.o_busy) chk("idle_no_push", 64'(bus.o_push_valid), 64'd0);
        if (src_mode) begin
            for (int k = 0; k < NR; k++) begin
                if (bus.i_req_valid[k] && bus.o_req_ready[k]) begin
                    exp_q.push_back('{k, src[k][0]});
                    void'(src[k].pop_front());
                end
            end
        end
        if (bus.o_push_valid && bus.i_push_ready) begin
            g = -1;
            for (int k = 0; k < NR; k++) if (bus.o_grant[k]) g = k;
            beat_log.push_back(g);
            chk("sb_pending", 64'(exp_q.size() > 0), 64'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("beat_data", 64'(bus.o_push_data), 64'(e.data));
                chk("beat_src", 64'(g), 64'(e.idx));
            end
        end
    endtask

    task automatic drive();
        for (int k = 0; k < NR; k++) begin
            bus.i_req_valid[k]       = en[k] && (src[k].size() > 0);
            bus.i_req_data[k*8 +: 8] = (src[k].size() > 0) ? src[k][0] : 8'h00;
        end
    endtask

    task automatic tick();
        drive();
        #4;
        sample();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int budget, output int ticks);
        ticks = 0;
        while (pending() && ticks < budget) begin
            tick();
            ticks++;
        end
        chk("drain_in_budget", 64'(pending()), 64'd0);
    endtask

    task automatic do_reset();
        rst              = 1'b1;
        en               = '0;
        src_mode         = 1'b1;
        bus.i_cnt_clr    = 1'b0;
        bus.i_push_ready = 1'b1;
        bus.i_req_valid  = '0;
        bus.i_req_data   = '0;
        for (int k = 0; k < NR; k++) src[k].delete();
        exp_q.delete();
        beat_log.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        // Reset state and a single two-beat transaction from requester 1.
        do_reset();
        src_mode = 1'b0;
        vecs[0] = '{4'b0000, 1'b1, 8'h00, 4'b0000, 1'b0, 4'b0000, 1'b0, 8'h00};
        vecs[1] = '{4'b0010, 1'b1, 8'hA1, 4'b0000, 1'b0, 4'b0000, 1'b0, 8'h00};
        vecs[2] = '{4'b0010, 1'b1, 8'hA1, 4'b0010, 1'b1, 4'b0010, 1'b1, 8'hA1};
        vecs[3] = '{4'b0010, 1'b1, 8'hB2, 4'b0010, 1'b1, 4'b0010, 1'b1, 8'hB2};
        vecs[4] = '{4'b0000, 1'b1, 8'h00, 4'b0010, 1'b0, 4'b0010, 1'b1, 8'h00};
        vecs[5] = '{4'b0000, 1'b1, 8'h00, 4'b0000, 1'b0, 4'b0000, 1'b0, 8'h00};
        for (int i = 0; i < 6; i++) begin
            bus.i_req_valid  = vecs[i].valid;
            bus.i_push_ready = vecs[i].ready;
            bus.i_req_data   = {16'h0000, vecs[i].d1, 8'h00};
            if (vecs[i].epv && vecs[i].ready) exp_q.push_back('{1, vecs[i].ed});
            #4;
            chk($sformatf("v%0d_grant", i), 64'(bus.o_grant), 64'(vecs[i].eg));
            chk($sformatf("v%0d_pvalid", i), 64'(bus.o_push_valid), 64'(vecs[i].epv));
            chk($sformatf("v%0d_ready", i), 64'(bus.o_req_ready), 64'(vecs[i].err));
            chk($sformatf("v%0d_busy", i), 64'(bus.o_busy), 64'(vecs[i].ebusy));
            if (vecs[i].epv) chk($sformatf("v%0d_data", i), 64'(bus.o_push_data), 64'(vecs[i].ed));
            sample();
            @(posedge clk);
            #1;
        end
        chk("t1_sb_empty", 64'(exp_q.size()), 64'd0);
        chk("t1_beats", 64'(beat_log.size()), 64'd2);

        // Fairness: all valid, FIFO always ready.
        do_reset();
        for (int k = 0; k < NR; k++) load(k, 8, 8'(k * 16));
        en = '1;
        drain(60, n);
        chk("fair_ticks", 64'(n), 64'd33);
        chk("fair_beats", 64'(beat_log.size()), 64'd32);
        for (int i = 0; i < beat_log.size() && i < 32; i++)
            chk($sformatf("fair_order%0d", i), 64'(beat_log[i]), 64'((i / 4) % 4));
`ifdef FIFO_PUSH_ARB_STATS_EN
        chk("fair_cnt", 64'(bus.o_beat_cnt), 64'h8888);
`else
        chk("fair_cnt_off", 64'(bus.o_beat_cnt), 64'd0);
`endif

        // Backpressure mid-burst on requester 2; requester 0 joins while stalled.
        do_reset();
        load(2, 6, 8'h20);
        load(0, 2, 8'h00);
        en = 4'b0100;
        for (int t = 0; t < 40 && pending(); t++) begin
            en[0]            = (t >= 2);
            bus.i_push_ready = !(t >= 3 && t < 8);
            tick();
            if (t >= 3 && t < 8) chk($sformatf("bp_hold%0d", t), 64'(bus.o_grant), 64'b0100);
        end
        chk("bp_drained", 64'(pending()), 64'd0);
        bp_exp = '{2, 2, 2, 2, 0, 0, 2, 2};
        chk("bp_beats", 64'(beat_log.size()), 64'd8);
        for (int i = 0; i < beat_log.size() && i < 8; i++)
            chk($sformatf("bp_order%0d", i), 64'(beat_log[i]), 64'(bp_exp[i]));

        // Valid drop: zero-bubble handover 0 -> 3, then 0 re-requests.
        do_reset();
        load(0, 2, 8'h40);
        load(3, 3, 8'h70);
        en = '1;
        n  = 0;
        while (pending() && n < 40) begin
            if (n == 4) load(0, 2, 8'h50);
            tick();
            n++;
            if (n == 4) chk("vd_handover", 64'(bus.o_grant), 64'b1000);
        end
        chk("vd_ticks", 64'(n), 64'd10);
        vd_exp = '{0, 0, 3, 3, 3, 0, 0};
        chk("vd_beats", 64'(beat_log.size()), 64'd7);
        for (int i = 0; i < beat_log.size() && i < 7; i++)
            chk($sformatf("vd_order%0d", i), 64'(beat_log[i]), 64'(vd_exp[i]));

        // Asynchronous reset in the middle of a requester-1 burst.
        do_reset();
        load(1, 8, 8'h90);
        en = '1;
        tick();
        tick();
        tick();
        drive();
        #1;
        chk("ar_pre_grant", 64'(bus.o_grant), 64'b0010);
        rst = 1'b1;
        #1;
        chk("ar_grant", 64'(bus.o_grant), 64'd0);
        chk("ar_pvalid", 64'(bus.o_push_valid), 64'd0);
        chk("ar_ready", 64'(bus.o_req_ready), 64'd0);
        chk("ar_busy", 64'(bus.o_busy), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("ar_cnt", 64'(bus.o_beat_cnt), 64'd0);
        exp_q.delete();
        beat_log.delete();
        src[1].delete();
        for (int k = 0; k < NR; k++) load(k, 2, 8'(8'hC0 + k * 4));
        for (int t = 0; t < 6 && beat_log.size() == 0; t++) tick();
        chk("ar_first_seen", 64'(beat_log.size() > 0), 64'd1);
        if (beat_log.size() > 0) chk("ar_first_src", 64'(beat_log[0]), 64'd0);

`ifdef FIFO_PUSH_ARB_STATS_EN
        // Saturation at 0xF and clear-over-increment priority.
        do_reset();
        load(0, 20, 8'h00);
        en = '1;
        drain(40, n);
        chk("st_sat", 64'(bus.o_beat_cnt), 64'h000F);
        load(0, 3, 8'h80);
        bus.i_cnt_clr = 1'b1;
        tick();
        bus.i_cnt_clr = 1'b0;
        chk("st_clr_beat", 64'(beat_log.size()), 64'd21);
        chk("st_clr", 64'(bus.o_beat_cnt), 64'd0);
        tick();
        chk("st_after_clr", 64'(bus.o_beat_cnt), 64'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/fifo_push_arbiter.md
Name: fifo_push_arbiter

Overview:
Round-robin arbiter that shares the single push port of one sync_fifo instance between NUM_REQ independent producers, each using a valid/ready handshake. It sits directly in front of the FIFO push side. It holds a grant for a burst of up to MAX_BURST beats, then rotates the grant.

Parameters:
NUM_REQ, 4, number of requesters (2..16)
WIDTH, 7, MSB index of a data beat; each beat is WIDTH+1 bits, matching sync_fifo
MAX_BURST, 4, maximum beats accepted per grant before forced rotation (1..255)
CNT_WIDTH, 16, width of each per-requester beat counter (optional feature only)

Ports:
i_clk  in  1  clock
i_rst  in  1  asynchronous, active-high reset
i_req_valid  in  NUM_REQ  per-requester valid
i_req_data  in  NUM_REQ*(WIDTH+1)  packed data; requester k occupies bits [k*(WIDTH+1) +: WIDTH+1]
o_req_ready  out  NUM_REQ  per-requester ready
o_push_valid  out  1  to FIFO i_push_valid
o_push_data  out  WIDTH+1  to FIFO i_push_data
i_push_ready  in  1  from FIFO o_push_ready
o_grant  out  NUM_REQ  one-hot current grant; all zero when idle
o_busy  out  1  high while in GRANT
i_cnt_clr  in  1  synchronous clear of beat counters (optional feature)
o_beat_cnt  out  NUM_REQ*CNT_WIDTH  per-requester accepted-beat counters (optional feature)

Behaviour:
- Clocking: single clock i_clk. Reset i_rst is asynchronous and active-high.
- Reset values: state=IDLE, o_grant=0, o_busy=0, o_push_valid=0, o_req_ready=0, burst_cnt=0, last_grant index=NUM_REQ-1 (so requester 0 has first priority), o_beat_cnt=0.
- Reset asserted mid-burst: all outputs drop in the same instant. A beat presented in that cycle is not counted as accepted.
- Beat definition: a beat is o_push_valid & i_push_ready at a rising edge of i_clk.
- State machine, two states:
  - IDLE: o_push_valid=0, all o_req_ready=0. If any i_req_valid is high, pick the first valid requester scanning from last_grant+1 upward with wrap. Register the grant, clear burst_cnt, go to GRANT. Arbitration latency is one cycle from valid to grant.
  - GRANT (grant g): o_push_valid=i_req_valid[g]; o_push_data=data[g]; o_req_ready[g]=i_push_ready; all other o_req_ready=0. Data and valid are combinational pass-through with no added latency.
- Release from GRANT happens when either:
  - a beat occurs and burst_cnt+1==MAX_BURST, or
  - i_req_valid[g]==0 in a GRANT cycle.
- On release:
  - last_grant<=g.
  - Re-arbitrate in the same cycle over the current i_req_valid, scanning from g+1. The scan includes g, last in order, only on a MAX_BURST release.
  - If a winner exists, load the new grant, clear burst_cnt and stay in GRANT. This gives a zero-bubble handover.
  - Otherwise go to IDLE.
- FIFO full (i_push_ready=0): grant is held, burst_cnt is frozen and no beat is counted. Rotation never occurs because of backpressure alone.
- burst_cnt: 8-bit, increments only on a beat, never exceeds MAX_BURST-1.
- Fairness: with all requesters continuously valid and the FIFO never full, grants are issued in order 0,1,2,3,0,... with exactly MAX_BURST beats each.
- Invariants: o_grant is always zero or one-hot. At most one o_req_ready is high. o_push_valid is never high in IDLE.

Optional Feature:
FIFO_PUSH_ARB_STATS_EN
- Defined: one saturating CNT_WIDTH-bit counter per requester, incremented on each accepted beat of that requester. The counter holds at all-ones. i_cnt_clr clears all counters on the next edge and takes priority over a same-cycle increment.
- Not defined: o_beat_cnt is driven to constant 0, i_cnt_clr is ignored, and no counter flops are synthesized.
- The port list is identical in both builds.

Test Plan:
- Reset then single requester: req1 pushes 0xA1,0xB2 with FIFO ready -> o_grant=4'b0010 one cycle after valid; FIFO receives 0xA1,0xB2 in order; release to IDLE when valid drops.
- All four valid, FIFO always ready, MAX_BURST=4 -> grant sequence 0,1,2,3,0 with 4 beats each and no idle cycle between grants; beat counts equal.
- Backpressure: req2 granted, i_push_ready low for 5 cycles mid-burst -> grant held, burst_cnt frozen, no duplicate or lost beat; burst completes after ready returns.
- Valid drop: req0 sends 2 beats then deasserts while req3 is valid -> same-cycle handover to req3 with no bubble; then req0 re-requests and is served after req3.
- Async reset mid-burst with req1 granted -> outputs 0 immediately; after release the first grant goes to req0 when all are valid.
- With FIFO_PUSH_ARB_STATS_EN, CNT_WIDTH=4: 20 beats from req0 -> counter saturates at 0xF; i_cnt_clr asserted with a concurrent beat -> counter reads 0.
